// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, FSM encoding and requester select codes
// Contents: bus widths, default starvation limit, FSM state type, select codes.
package mem_arbiter_pkg;

    localparam int MA_ADDR_W        = 32;
    localparam int MA_DATA_W        = 128;
    localparam int MA_MASK_W        = MA_DATA_W / 8;
    localparam int MA_MAX_DC_STREAK = 4;
    localparam int MA_CNT_W         = $clog2(MA_MAX_DC_STREAK + 1);

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_ISSUE = 2'd1,
        MA_WAIT  = 2'd2
    } ma_state_t;

    localparam logic MA_SEL_IC = 1'b0;
    localparam logic MA_SEL_DC = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - IC, DC and memory port bundle of the memory arbiter
// Modports:
//   slave  - the arbiter: takes cache requests and memory responses,
//            drives cache readies/responses and the memory request.
//   master - the surrounding caches and memory model.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MA_ADDR_W,
    parameter int DATA_W = MA_DATA_W,
    parameter int MASK_W = MA_MASK_W
) ();

    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_req_wdata;
    logic [MASK_W-1:0] dc_req_wmask;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - fixed DC-priority pick with starvation override for IC
// Ports:
//   ic_valid, dc_valid  in   pending requests
//   streak_sat          in   DC has won the maximum run while IC waited
//   grant_ic, grant_dc  out  one-hot (or none) winner
module mem_arb_pick (
    input  logic ic_valid,
    input  logic dc_valid,
    input  logic streak_sat,
    output logic grant_ic,
    output logic grant_dc
);

    // DC yields only when IC is waiting and DC has used up its run.
    assign grant_dc = dc_valid && !(ic_valid && streak_sat);
    assign grant_ic = ic_valid && !grant_dc;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between IC and DC, one transaction in flight
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high
//   bus    slave modport of mem_arbiter_if (IC, DC and memory handshakes)
//   busy   out  a transaction is being issued or awaiting its response
//   err    out  sticky: memory response seen while no read was outstanding
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = MA_ADDR_W,
    parameter int DATA_W        = MA_DATA_W,
    parameter int MASK_W        = MA_MASK_W,
    parameter int MAX_DC_STREAK = MA_MAX_DC_STREAK,
    parameter int CNT_W         = MA_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic          err
);

    ma_state_t         state;
    ma_state_t         state_nxt;
    logic              sel_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [CNT_W-1:0]  streak;
    logic              streak_sat;
    logic              grant_ic;
    logic              grant_dc;
    logic              take;

    assign streak_sat = (streak == CNT_W'(MAX_DC_STREAK));

    mem_arb_pick u_pick (
        .ic_valid   (bus.ic_req_valid),
        .dc_valid   (bus.dc_req_valid),
        .streak_sat (streak_sat),
        .grant_ic   (grant_ic),
        .grant_dc   (grant_dc)
    );

    // A grant is only taken while nothing is in flight.
    assign take = (state == MA_IDLE) && (grant_ic || grant_dc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MA_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        bus.ic_req_ready  = 1'b0;
        bus.dc_req_ready  = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.ic_resp_valid = 1'b0;
        bus.dc_resp_valid = 1'b0;
        case (state)
            MA_IDLE: begin
                bus.ic_req_ready = grant_ic;
                bus.dc_req_ready = grant_dc;
                if (grant_ic || grant_dc) begin
                    state_nxt = MA_ISSUE;
                end
            end
            MA_ISSUE: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    // Writes are fire-and-forget; only reads wait for data.
                    state_nxt = rw_q ? MA_IDLE : MA_WAIT;
                end
            end
            MA_WAIT: begin
                if (bus.mem_resp_valid) begin
                    bus.ic_resp_valid = (sel_q == MA_SEL_IC);
                    bus.dc_resp_valid = (sel_q == MA_SEL_DC);
                    state_nxt         = MA_IDLE;
                end
            end
            default: state_nxt = MA_IDLE;
        endcase
    end

    // Request latches and the DC run counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q   <= MA_SEL_IC;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            streak  <= '0;
        end else if (take) begin
            sel_q   <= grant_dc ? MA_SEL_DC : MA_SEL_IC;
            rw_q    <= grant_dc && bus.dc_req_rw;
            addr_q  <= grant_dc ? bus.dc_req_addr : bus.ic_req_addr;
            wdata_q <= bus.dc_req_wdata;
            wmask_q <= bus.dc_req_wmask;
            if (grant_dc && bus.ic_req_valid) begin
                streak <= streak_sat ? streak : streak + 1'b1;
            end else begin
                streak <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (bus.mem_resp_valid && (state != MA_WAIT)) begin
            err <= 1'b1;
        end
    end

    assign bus.mem_req_rw    = rw_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wmask = wmask_q;
    assign bus.ic_resp_data  = bus.mem_resp_data;
    assign bus.dc_resp_data  = bus.mem_resp_data;
    assign busy              = (state != MA_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAXS = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic err;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_DC_STREAK(MAXS), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Transaction-level model: at most one transaction, either waiting for
    // memory to accept it or (reads) waiting for its data.
    bit          m_act    = 0;
    bit          m_issued = 0;
    bit          m_src    = 0;
    bit          m_rw     = 0;
    bit          m_err    = 0;
    logic [31:0] m_addr   = '0;
    logic [127:0] m_wdata = '0;
    logic [15:0] m_wmask  = '0;
    int          m_streak = 0;
    bit          m_dcwin;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 0; m_issued = 0; m_src = 0; m_rw = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_wmask = '0; m_streak = 0;
        end else begin
            if (bus.mem_resp_valid && !(m_act && m_issued)) m_err = 1;
            if (!m_act) begin
                m_dcwin = bus.dc_req_valid && !(bus.ic_req_valid && m_streak >= MAXS);
                if (m_dcwin || bus.ic_req_valid) begin
                    m_act    = 1;
                    m_issued = 0;
                    m_src    = m_dcwin;
                    m_rw     = m_dcwin && bus.dc_req_rw;
                    m_addr   = m_dcwin ? bus.dc_req_addr : bus.ic_req_addr;
                    m_wdata  = bus.dc_req_wdata;
                    m_wmask  = bus.dc_req_wmask;
                    if (m_dcwin && bus.ic_req_valid)
                        m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
                    else
                        m_streak = 0;
                end
            end else if (!m_issued) begin
                if (bus.mem_req_ready) begin
                    if (m_rw) m_act = 0;
                    else      m_issued = 1;
                end
            end else if (bus.mem_resp_valid) begin
                m_act = 0;
            end
        end
    end

    // Observation logs used by the directed literal checks.
    int          g_src[$];
    int          g_cyc[$];
    logic [31:0] hs_addr[$];
    bit          hs_rw[$];
    int          dcr_cyc[$];
    int          n_mrv = 0;
    int          n_icr = 0;
    int          n_dcr = 0;
    int          icr_cyc = 0;
    logic [127:0] last_ic_data = '0;
    bit          e_dc;
    bit          e_ic;

    always @(negedge clk) begin
        if (!reset) begin
            e_dc = !m_act && bus.dc_req_valid && !(bus.ic_req_valid && m_streak >= MAXS);
            e_ic = !m_act && bus.ic_req_valid && !e_dc;
            check("busy",          128'(busy),              128'(m_act));
            check("err",           128'(err),               128'(m_err));
            check("ic_req_ready",  128'(bus.ic_req_ready),  128'(e_ic));
            check("dc_req_ready",  128'(bus.dc_req_ready),  128'(e_dc));
            check("mem_req_valid", 128'(bus.mem_req_valid), 128'(m_act && !m_issued));
            check("mem_req_rw",    128'(bus.mem_req_rw),    128'(m_rw));
            check("mem_req_addr",  128'(bus.mem_req_addr),  128'(m_addr));
            check("mem_req_wdata", bus.mem_req_wdata,       m_wdata);
            check("mem_req_wmask", 128'(bus.mem_req_wmask), 128'(m_wmask));
            check("ic_resp_valid", 128'(bus.ic_resp_valid),
                  128'(m_act && m_issued && bus.mem_resp_valid && !m_src));
            check("dc_resp_valid", 128'(bus.dc_resp_valid),
                  128'(m_act && m_issued && bus.mem_resp_valid && m_src));
            check("ic_resp_data",  bus.ic_resp_data,        bus.mem_resp_data);
            check("dc_resp_data",  bus.dc_resp_data,        bus.mem_resp_data);
            if (bus.ic_req_ready) begin g_src.push_back(0); g_cyc.push_back(cyc); end
            if (bus.dc_req_ready) begin g_src.push_back(1); g_cyc.push_back(cyc); end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                hs_addr.push_back(bus.mem_req_addr);
                hs_rw.push_back(bus.mem_req_rw);
            end
            if (bus.mem_req_valid) n_mrv++;
            if (bus.ic_resp_valid) begin
                n_icr++; icr_cyc = cyc; last_ic_data = bus.ic_resp_data;
            end
            if (bus.dc_resp_valid) begin n_dcr++; dcr_cyc.push_back(cyc); end
        end
    end

    // Memory responder: accepts after ready_delay cycles, answers reads
    // resp_delay cycles into the wait with data derived from the address.
    int          ready_delay = 0;
    int          resp_delay  = 0;
    int          wait_cnt    = 0;
    int          resp_cnt    = 0;
    bit          pend        = 0;
    bit          auto_mem    = 1;
    logic [31:0] resp_addr   = '0;

    initial begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                wait_cnt = 0; resp_cnt = 0; pend = 0;
                if (auto_mem) begin
                    bus.mem_req_ready  = 1'b0;
                    bus.mem_resp_valid = 1'b0;
                end
            end else if (auto_mem) begin
                bus.mem_req_ready  = 1'b0;
                bus.mem_resp_valid = 1'b0;
                if (pend) begin
                    if (resp_cnt == resp_delay) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_resp_data  = {4{32'hA5A5_A5A5}} ^ {96'd0, resp_addr};
                        pend = 0;
                    end else begin
                        resp_cnt++;
                    end
                end
                if (bus.mem_req_valid) begin
                    if (wait_cnt == ready_delay) begin
                        bus.mem_req_ready = 1'b1;
                        wait_cnt = 0;
                        if (!bus.mem_req_rw) begin
                            pend = 1; resp_cnt = 0; resp_addr = bus.mem_req_addr;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    task automatic wait_grant(input bit dc, input string nm);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (dc ? bus.dc_req_ready : bus.ic_req_ready) ok = 1;
        end
        check(nm, 128'(ok), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        check(nm, 128'(ok), 128'(1));
        @(posedge clk);
        #1;
    endtask

    int g0, hs0, n0, n1, dc0;
    int exp3[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit done3;

    initial begin
        bus.ic_req_valid = 1'b0;
        bus.ic_req_addr  = '0;
        bus.dc_req_valid = 1'b0;
        bus.dc_req_rw    = 1'b0;
        bus.dc_req_addr  = '0;
        bus.dc_req_wdata = '0;
        bus.dc_req_wmask = '0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_busy",      128'(busy),              128'(0));
        check("rst_err",       128'(err),               128'(0));
        check("rst_mem_valid", 128'(bus.mem_req_valid), 128'(0));
        check("rst_mem_addr",  128'(bus.mem_req_addr),  128'(0));
        check("rst_mem_wmask", 128'(bus.mem_req_wmask), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: IC read 0x100, response in the second wait cycle
        ready_delay = 0; resp_delay = 1;
        g0 = g_src.size(); hs0 = hs_addr.size(); n0 = n_icr;
        bus.ic_req_valid = 1'b1; bus.ic_req_addr = 32'h100;
        wait_grant(0, "t1_grant");
        bus.ic_req_valid = 1'b0;
        wait_idle("t1_idle");
        check("t1_grant_cnt", 128'(g_src.size() - g0), 128'(1));
        check("t1_hs_addr",   128'(hs_addr[hs0]),      128'(32'h100));
        check("t1_hs_rw",     128'(hs_rw[hs0]),        128'(0));
        check("t1_resp_cnt",  128'(n_icr - n0),        128'(1));
        check("t1_resp_lat",  128'(icr_cyc - g_cyc[g0]), 128'(3));
        check("t1_resp_data", last_ic_data, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A4A5);

        // 2: DC write 0x200, memory stalls 3 cycles
        ready_delay = 3;
        hs0 = hs_addr.size(); n0 = n_mrv; n1 = n_dcr;
        bus.dc_req_valid = 1'b1; bus.dc_req_rw = 1'b1; bus.dc_req_addr = 32'h200;
        bus.dc_req_wdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
        bus.dc_req_wmask = 16'hFFFF;
        wait_grant(1, "t2_grant");
        bus.dc_req_valid = 1'b0; bus.dc_req_wdata = '0; bus.dc_req_wmask = '0;
        wait_idle("t2_idle");
        check("t2_valid_cycles", 128'(n_mrv - n0),   128'(4));
        check("t2_no_dc_resp",   128'(n_dcr - n1),   128'(0));
        check("t2_hs_addr",      128'(hs_addr[hs0]), 128'(32'h200));
        check("t2_hs_rw",        128'(hs_rw[hs0]),   128'(1));

        // 3: both requesting continuously, DC reads
        ready_delay = 0; resp_delay = 0;
        g0 = g_src.size();
        bus.ic_req_valid = 1'b1; bus.ic_req_addr = 32'h400;
        bus.dc_req_valid = 1'b1; bus.dc_req_rw = 1'b0; bus.dc_req_addr = 32'h500;
        done3 = 0;
        for (int i = 0; i < 400 && !done3; i++) begin
            @(negedge clk);
            #1;
            if (g_src.size() - g0 >= 10) done3 = 1;
        end
        check("t3_done", 128'(done3), 128'(1));
        @(posedge clk);
        #1;
        bus.ic_req_valid = 1'b0; bus.dc_req_valid = 1'b0;
        wait_idle("t3_idle");
        for (int i = 0; i < 10; i++) begin
            if (g0 + i < g_src.size())
                check($sformatf("t3_order%0d", i), 128'(g_src[g0 + i]), 128'(exp3[i]));
        end

        // 6: back-to-back DC reads
        g0 = g_src.size(); hs0 = hs_addr.size(); dc0 = dcr_cyc.size();
        bus.dc_req_valid = 1'b1; bus.dc_req_rw = 1'b0; bus.dc_req_addr = 32'h300;
        wait_grant(1, "t6_grant0");
        bus.dc_req_addr = 32'h340;
        wait_grant(1, "t6_grant1");
        bus.dc_req_valid = 1'b0;
        wait_idle("t6_idle");
        check("t6_hs_addr0", 128'(hs_addr[hs0]),     128'(32'h300));
        check("t6_hs_addr1", 128'(hs_addr[hs0 + 1]), 128'(32'h340));
        check("t6_regrant",  128'(g_cyc[g0 + 1] - dcr_cyc[dc0]), 128'(1));

        // 4: stray memory response while idle
        auto_mem = 0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        n0 = n_icr; n1 = n_dcr;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 128'h5A;
        @(posedge clk);
        #1;
        bus.mem_resp_valid = 1'b0;
        check("t4_err_set", 128'(err), 128'(1));
        repeat (5) @(posedge clk);
        #1;
        check("t4_err_sticky", 128'(err),               128'(1));
        check("t4_no_resp",    128'((n_icr - n0) + (n_dcr - n1)), 128'(0));
        #2;
        reset = 1'b1;
        #1;
        check("t4_err_clr", 128'(err), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        auto_mem = 1;

        // 5: reset in the middle of a read wait
        ready_delay = 0; resp_delay = 10;
        bus.ic_req_valid = 1'b1; bus.ic_req_addr = 32'h600;
        wait_grant(0, "t5_grant");
        bus.ic_req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("t5_busy_before", 128'(busy), 128'(1));
        reset = 1'b1;
        #1;
        check("t5_busy_rst",  128'(busy),              128'(0));
        check("t5_valid_rst", 128'(bus.mem_req_valid), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        resp_delay = 0;
        n0 = n_icr;
        bus.ic_req_valid = 1'b1; bus.ic_req_addr = 32'h700;
        wait_grant(0, "t5_grant2");
        bus.ic_req_valid = 1'b0;
        wait_idle("t5_idle");
        check("t5_resp_cnt",  128'(n_icr - n0), 128'(1));
        check("t5_resp_data", last_ic_data, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A2A5);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
